qeciphy_tx_boundary_gen_param: RTL

Parametrised TX boundary generator for the QECIPHY transmit datapath. It produces the per-slot markers the TX framer uses to insert frame-alignment words (FAW) and CRC words: a FAW slot, then CRC groups of data slots, each closed by one CRC slot. Compared with the fixed 64-slot generator, it adds:
- configurable group and frame geometry,
- a configurable almost-FAW lead,
- stall (advance) support,
- graceful stop and restart,
- slot and frame counters.

---
 rtl/qeciphy_pkg.sv | 28 ++
 rtl/qeciphy_wrap_counter.sv | 34 +++
 rtl/qeciphy_tx_boundary_gen_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types and helpers for the QECIPHY TX boundary generator.
// Frame layout: slot 0 is the FAW, then CRC_PER_FAW groups of data slots each closed by a CRC slot.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } bnd_state_e;

  typedef enum logic [1:0] {
    SLOT_FAW  = 2'd0,
    SLOT_CRC  = 2'd1,
    SLOT_DATA = 2'd2
  } slot_kind_e;

  function automatic int qeciphy_faw_period(input int data_per_crc, input int crc_per_faw);
    return 1 + crc_per_faw * (data_per_crc + 1);
  endfunction

  // Slots beyond the last CRC never occur, so the modulo test alone identifies CRC slots.
  function automatic slot_kind_e qeciphy_slot_kind(input int slot, input int data_per_crc);
    if (slot == 0) return SLOT_FAW;
    if ((slot % (data_per_crc + 1)) == 0) return SLOT_CRC;
    return SLOT_DATA;
  endfunction

endpackage

// File: rtl/qeciphy_wrap_counter.sv
// Modulo-MOD counter with enable and synchronous clear; wrap_o flags the enabled step
// from MOD-1 back to 0.
module qeciphy_wrap_counter #(
  parameter  int MOD = 64,
  localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (wrap_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/qeciphy_tx_boundary_gen_param.sv
// Parametrised TX boundary generator: FAW / CRC / data slot markers with almost-FAW lead,
// stall support, graceful stop at frame end, restart, and a frame counter.
module qeciphy_tx_boundary_gen_param
  import qeciphy_pkg::*;
#(
  parameter  int DATA_PER_CRC = 6,
  parameter  int CRC_PER_FAW  = 9,
  parameter  int ALMOST_LEAD  = 1,
  parameter  int FRAME_CNT_W  = 16,
  localparam int PERIOD       = qeciphy_faw_period(DATA_PER_CRC, CRC_PER_FAW),
  localparam int SLOT_W       = $clog2(PERIOD)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   advance_i,
  input  logic                   restart_i,
  output logic                   faw_boundary_o,
  output logic                   almost_faw_boundary_o,
  output logic                   crc_boundary_o,
  output logic                   data_slot_o,
  output logic [SLOT_W-1:0]      slot_idx_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   active_o
);

  localparam int                PC_W        = $clog2(ALMOST_LEAD + 1);
  localparam logic [PC_W-1:0]   LEAD        = PC_W'(ALMOST_LEAD);
  localparam logic [SLOT_W-1:0] ALMOST_SLOT = SLOT_W'(PERIOD - ALMOST_LEAD);

  if (ALMOST_LEAD < 1 || ALMOST_LEAD > DATA_PER_CRC) begin : g_bad_lead
    $error("ALMOST_LEAD must lie within 1..DATA_PER_CRC");
  end
  if (DATA_PER_CRC < 1 || CRC_PER_FAW < 1) begin : g_bad_geom
    $error("DATA_PER_CRC and CRC_PER_FAW must be at least 1");
  end

  bnd_state_e             state_q, state_d;
  logic [PC_W-1:0]        prime_cnt_q, prime_cnt_d;
  logic                   stop_pending_q, stop_pending_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   frame_inc;
  logic                   slot_en, slot_clr, slot_wrap;
  logic [SLOT_W-1:0]      slot;
  slot_kind_e             kind;

  // Restart abandons the frame, so it must not step the slot counter.
  assign slot_en  = (state_q == ST_RUN) && advance_i && !restart_i;
  assign slot_clr = (state_d != ST_RUN);

  qeciphy_wrap_counter #(.MOD(PERIOD)) u_slot_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (slot_en),
    .clr_i   (slot_clr),
    .cnt_o   (slot),
    .wrap_o  (slot_wrap)
  );

  always_comb begin
    state_d        = state_q;
    prime_cnt_d    = prime_cnt_q;
    stop_pending_d = stop_pending_q;
    frame_inc      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stop_pending_d = 1'b0;
        if (enable_i && !restart_i) begin
          state_d     = ST_PRIME;
          prime_cnt_d = LEAD;
        end
      end
      ST_PRIME: begin
        if (restart_i) begin
          prime_cnt_d    = LEAD;
          stop_pending_d = !enable_i;
        end else if (!enable_i) begin
          state_d        = ST_IDLE;
          prime_cnt_d    = '0;
          stop_pending_d = 1'b0;
        end else begin
          stop_pending_d = 1'b0;
          if (advance_i) begin
            if (prime_cnt_q == PC_W'(1)) begin
              state_d     = ST_RUN;
              prime_cnt_d = '0;
              frame_inc   = 1'b1;
            end else begin
              prime_cnt_d = prime_cnt_q - PC_W'(1);
            end
          end
        end
      end
      ST_RUN: begin
        if (restart_i) begin
          state_d        = ST_PRIME;
          prime_cnt_d    = LEAD;
          stop_pending_d = !enable_i;
        end else begin
          // A stop decided on the final advance of the frame still lands in IDLE.
          stop_pending_d = !enable_i;
          if (slot_wrap) begin
            if (!enable_i) begin
              state_d        = ST_IDLE;
              stop_pending_d = 1'b0;
            end else begin
              frame_inc = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        prime_cnt_d    = '0;
        stop_pending_d = 1'b0;
      end
    endcase
    frame_cnt_d = frame_inc ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      prime_cnt_q    <= '0;
      stop_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      prime_cnt_q    <= prime_cnt_d;
      stop_pending_q <= stop_pending_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign kind = qeciphy_slot_kind(int'(slot), DATA_PER_CRC);

  assign faw_boundary_o        = (state_q == ST_RUN) && (kind == SLOT_FAW);
  assign crc_boundary_o        = (state_q == ST_RUN) && (kind == SLOT_CRC);
  assign data_slot_o           = (state_q == ST_RUN) && (kind == SLOT_DATA);
  assign almost_faw_boundary_o = ((state_q == ST_PRIME) && (prime_cnt_q == LEAD)) ||
                                 ((state_q == ST_RUN) && (slot == ALMOST_SLOT) && !stop_pending_q);
  assign slot_idx_o            = slot;
  assign frame_cnt_o           = frame_cnt_q;
  assign active_o              = (state_q == ST_PRIME) || (state_q == ST_RUN);

endmodule
